serial_restoring_divider: RTL

Multi-cycle unsigned restoring divider for the arithmetic datapath. It computes the inverse operation of the adder chain: one quotient bit per clock, by trial subtraction. Each trial subtraction uses the adder with the divisor inverted and carry-in tied to 1. It sits beside the lookahead adder and takes its operands through a start/busy/done handshake.

---
 rtl/serial_restoring_divider.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock by trial
// subtraction, with a start/busy/done handshake and a divide-by-zero shortcut.
module serial_restoring_divider #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quot,
    output logic [n-1:0] rem,
    output logic         dz
);

    localparam int CW = $clog2(n);
    localparam int TW = n + 2;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT         state;
    logic [CW-1:0] count;
    logic [n-1:0]  qReg;
    logic [n-1:0]  dReg;
    logic [n:0]    rReg;

    logic [2*n:0]  shifted;
    logic [n:0]    rShift;
    logic [TW-1:0] trial;
    logic          carry;
    logic [n:0]    rNext;
    logic [n-1:0]  qNext;

    // Trial subtraction R - {0,D} done as an add of the inverted divisor with
    // carry-in 1; the carry out of bit n means no borrow, so the bit is kept.
    assign shifted = {rReg, qReg} << 1;
    assign rShift  = shifted[2*n:n];
    assign trial   = {1'b0, rShift} + {1'b0, ~{1'b0, dReg}} + TW'(1);
    assign carry   = trial[n+1];
    assign rNext   = carry ? trial[n:0] : rShift;
    assign qNext   = shifted[n-1:0] | {{(n-1){1'b0}}, carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            count <= '0;
            qReg  <= '0;
            rReg  <= '0;
            dReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (B != '0) begin
                            qReg  <= A;
                            dReg  <= B;
                            rReg  <= '0;
                            count <= '0;
                            dz    <= 1'b0;
                            state <= RUN;
                        end else begin
                            quot  <= '1;
                            rem   <= A;
                            dz    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    rReg  <= rNext;
                    qReg  <= qNext;
                    count <= count + 1'b1;
                    // Results are published on the same edge as the last iteration.
                    if (count == LAST) begin
                        quot  <= qNext;
                        rem   <= rNext[n-1:0];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
